rsss_lock_ctrl: RTL and testbench

Parametrised successor to the serial password-lock FSM. It checks a CODE_W-bit entry against a stored code, serially MSB first, one bit per clock. The block adds a constant-time compare, a working wrong-attempt counter with buzzer lockout, auto-relock, and re-programming of the code while open. It sits between the keypad/entry logic and the lock actuator and buzzer drivers.

---
 rtl/rsss_pkg.sv | 28 ++
 rtl/rsss_timer.sv | 37 +++
 rtl/rsss_lock_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_rsss_lock_ctrl.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsss_pkg.sv
// rsss_pkg: shared definitions for the serial code lock.
//   - rsss_state_t : FSM state encoding (IDLE=0 .. LOCKOUT=4, 3 bits)
//   - RSSS_DEFAULT_CODE : code loaded at reset (16'h1732, decimal 5938)
//   - rsss_timer_w() : width of the shared lockout / auto-relock timer
package rsss_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_LOCKOUT = 3'd4
    } rsss_state_t;

    localparam logic [15:0] RSSS_DEFAULT_CODE = 16'h1732;

    // Timer must hold the larger of the two durations; never narrower than 1 bit.
    function automatic int rsss_timer_w(input int lockout_cyc, input int open_cyc);
        int m;
        m = (lockout_cyc > open_cyc) ? lockout_cyc : open_cyc;
        if (m < 32'sd1) begin
            return 32'sd1;
        end else begin
            return $clog2(m + 32'sd1);
        end
    endfunction

endpackage

// File: rtl/rsss_timer.sv
// rsss_timer: load / decrement / expire down-counter.
//   clk      : clock, rising edge
//   rst      : synchronous active-low reset
//   load     : load load_val (has priority over en)
//   load_val : start value, i.e. number of cycles until expiry
//   en       : decrement by one per clock while non-zero
//   last     : high during the final counted cycle (count == 1)
module rsss_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         last
);

    logic [W-1:0] cnt_r;

    // Down-counter; stops at zero so a stale value never wraps around.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != {W{1'b0}})) begin
            cnt_r <= cnt_r - W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Loaded with N, 'last' is seen on the Nth cycle so the owner leaves on the Nth edge.
    assign last = (cnt_r == W'(1'b1));

endmodule

// File: rtl/rsss_lock_ctrl.sv
// rsss_lock_ctrl: serial code lock with constant-time compare, failure
// counting with buzzer lockout, optional auto-relock and code re-programming.
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset
//   code_in    : entered code, captured on code_valid in IDLE
//   code_valid : single-cycle request to check code_in
//   relock     : OPEN -> IDLE
//   prog_en    : store prog_code as the new code (OPEN only)
//   prog_code  : new code value
//   out        : lock drive, 0 = unlocked (OPEN), 1 = locked
//   out_buzz   : 1 during LOCKOUT
//   busy       : 1 in CHECK, FAIL, LOCKOUT (code_valid ignored)
//   state      : current state encoding
//   fail_cnt   : consecutive failed attempts
module rsss_lock_ctrl
    import rsss_pkg::*;
#(
    parameter int                CODE_W       = 16,
    parameter logic [CODE_W-1:0] DEFAULT_CODE = CODE_W'(RSSS_DEFAULT_CODE),
    parameter int                MAX_TRIES    = 3,
    parameter int                LOCKOUT_CYC  = 1000,
    parameter int                OPEN_CYC     = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CODE_W-1:0]                code_in,
    input  logic                             code_valid,
    input  logic                             relock,
    input  logic                             prog_en,
    input  logic [CODE_W-1:0]                prog_code,
    output logic                             out,
    output logic                             out_buzz,
    output logic                             busy,
    output logic [2:0]                       state,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt
);

    localparam int                FC_W        = $clog2(MAX_TRIES + 1);
    localparam int                IDX_W       = $clog2(CODE_W);
    localparam int                TMR_W       = rsss_timer_w(LOCKOUT_CYC, OPEN_CYC);
    localparam logic              AUTO_RELOCK = (OPEN_CYC > 0);
    localparam logic [FC_W-1:0]   FC_MAX      = FC_W'(MAX_TRIES);
    localparam logic [TMR_W-1:0]  LOCK_LOAD   = TMR_W'(LOCKOUT_CYC);
    localparam logic [TMR_W-1:0]  OPEN_LOAD   = TMR_W'(OPEN_CYC);

    rsss_state_t        state_r;
    rsss_state_t        nxt_s;
    logic [CODE_W-1:0]  code_r;
    logic [CODE_W-1:0]  shift_r;
    logic [IDX_W-1:0]   idx_r;
    logic               mism_r;
    logic               cmp_done_r;
    logic [FC_W-1:0]    fail_nxt_s;
    logic [FC_W-1:0]    fail_inc_s;
    logic               tmr_load_s;
    logic [TMR_W-1:0]   tmr_val_s;
    logic               tmr_en_s;
    logic               tmr_last_s;

    // One timer serves both LOCKOUT duration and OPEN auto-relock; the states never overlap.
    rsss_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .en       (tmr_en_s),
        .last     (tmr_last_s)
    );

    assign tmr_en_s = (state_r == ST_LOCKOUT) || (state_r == ST_OPEN);

    // Next-state, failure-count and timer-load decode.
    always_comb begin
        nxt_s      = state_r;
        fail_nxt_s = fail_cnt;
        tmr_load_s = 1'b0;
        tmr_val_s  = LOCK_LOAD;
        if (fail_cnt == FC_MAX) begin
            fail_inc_s = FC_MAX;
        end else begin
            fail_inc_s = fail_cnt + FC_W'(1'b1);
        end
        case (state_r)
            ST_IDLE: begin
                if (code_valid) begin
                    nxt_s = ST_CHECK;
                end else begin
                    nxt_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                // The verdict is taken one cycle after bit 0 from the registered
                // sticky flag, so every entry spends CODE_W+1 cycles here.
                if (cmp_done_r) begin
                    if (mism_r) begin
                        nxt_s = ST_FAIL;
                    end else begin
                        nxt_s      = ST_OPEN;
                        fail_nxt_s = {FC_W{1'b0}};
                        tmr_load_s = AUTO_RELOCK;
                        tmr_val_s  = OPEN_LOAD;
                    end
                end else begin
                    nxt_s = ST_CHECK;
                end
            end
            ST_OPEN: begin
                if (relock || (AUTO_RELOCK && tmr_last_s)) begin
                    nxt_s = ST_IDLE;
                end else begin
                    nxt_s = ST_OPEN;
                end
            end
            ST_FAIL: begin
                fail_nxt_s = fail_inc_s;
                if (fail_inc_s == FC_MAX) begin
                    nxt_s      = ST_LOCKOUT;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = LOCK_LOAD;
                end else begin
                    nxt_s = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_last_s) begin
                    nxt_s      = ST_IDLE;
                    fail_nxt_s = {FC_W{1'b0}};
                end else begin
                    nxt_s = ST_LOCKOUT;
                end
            end
            default: begin
                nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered outputs, all derived from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            out      <= 1'b1;
            out_buzz <= 1'b0;
            busy     <= 1'b0;
            fail_cnt <= {FC_W{1'b0}};
        end else begin
            state_r  <= nxt_s;
            out      <= (nxt_s != ST_OPEN);
            out_buzz <= (nxt_s == ST_LOCKOUT);
            busy     <= (nxt_s != ST_IDLE) && (nxt_s != ST_OPEN);
            fail_cnt <= fail_nxt_s;
        end
    end

    assign state = state_r;

    // Entry capture, bit-serial compare (MSB first, no early exit) and stored code.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_r    <= {CODE_W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            mism_r     <= 1'b0;
            cmp_done_r <= 1'b0;
            code_r     <= DEFAULT_CODE;
        end else begin
            if ((state_r == ST_IDLE) && code_valid) begin
                shift_r    <= code_in;
                idx_r      <= IDX_W'(CODE_W - 1);
                mism_r     <= 1'b0;
                cmp_done_r <= 1'b0;
            end else if ((state_r == ST_CHECK) && !cmp_done_r) begin
                mism_r  <= mism_r | (shift_r[CODE_W-1] ^ code_r[idx_r]);
                shift_r <= {shift_r[CODE_W-2:0], 1'b0};
                if (idx_r == {IDX_W{1'b0}}) begin
                    cmp_done_r <= 1'b1;
                end else begin
                    idx_r <= idx_r - IDX_W'(1'b1);
                end
            end else begin
                shift_r <= shift_r;
            end
            // A write coinciding with relock or timeout still lands: only the current state matters.
            if ((state_r == ST_OPEN) && prog_en) begin
                code_r <= prog_code;
            end else begin
                code_r <= code_r;
            end
        end
    end

endmodule

// File: tb/tb_rsss_lock_ctrl.sv
module tb_rsss_lock_ctrl;

    localparam int CW  = 16;
    localparam int MT  = 3;
    localparam int LC  = 50;
    localparam int OCB = 20;

    localparam logic [2:0]  S_IDLE    = 3'd0;
    localparam logic [2:0]  S_CHECK   = 3'd1;
    localparam logic [2:0]  S_OPEN    = 3'd2;
    localparam logic [2:0]  S_FAIL    = 3'd3;
    localparam logic [2:0]  S_LOCKOUT = 3'd4;
    localparam logic [15:0] DEF_CODE  = 16'd5938;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] a_code_in = 16'd0, a_prog_code = 16'd0;
    logic        a_code_valid = 1'b0, a_relock = 1'b0, a_prog_en = 1'b0;
    logic        a_out, a_buzz, a_busy;
    logic [2:0]  a_state;
    logic [1:0]  a_fcnt;

    logic [15:0] b_code_in = 16'd0, b_prog_code = 16'd0;
    logic        b_code_valid = 1'b0, b_relock = 1'b0, b_prog_en = 1'b0;
    logic        b_out, b_buzz, b_busy;
    logic [2:0]  b_state;
    logic [1:0]  b_fcnt;

    int checks   = 0;
    int failures = 0;

    // reference model: stored codes and consecutive-failure count
    logic [15:0] m_code_a = DEF_CODE;
    logic [15:0] m_code_b = DEF_CODE;
    int          m_fail_a = 0;

    rsss_lock_ctrl #(
        .CODE_W(CW), .MAX_TRIES(MT), .LOCKOUT_CYC(LC), .OPEN_CYC(0)
    ) dut_a (
        .clk(clk), .rst(rst), .code_in(a_code_in), .code_valid(a_code_valid),
        .relock(a_relock), .prog_en(a_prog_en), .prog_code(a_prog_code),
        .out(a_out), .out_buzz(a_buzz), .busy(a_busy), .state(a_state), .fail_cnt(a_fcnt)
    );

    rsss_lock_ctrl #(
        .CODE_W(CW), .MAX_TRIES(MT), .LOCKOUT_CYC(LC), .OPEN_CYC(OCB)
    ) dut_b (
        .clk(clk), .rst(rst), .code_in(b_code_in), .code_valid(b_code_valid),
        .relock(b_relock), .prog_en(b_prog_en), .prog_code(b_prog_code),
        .out(b_out), .out_buzz(b_buzz), .busy(b_busy), .state(b_state), .fail_cnt(b_fcnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse code_valid, then advance to 16 edges after the sampling edge.
    task automatic drive_code(input bit sel_b, input logic [15:0] c);
        if (sel_b) begin
            b_code_in = c; b_code_valid = 1'b1;
        end else begin
            a_code_in = c; a_code_valid = 1'b1;
        end
        tick();
        a_code_valid = 1'b0;
        b_code_valid = 1'b0;
        repeat (CW) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if ({a_state, a_out, a_buzz, a_busy, a_fcnt} !== {S_IDLE, 1'b1, 1'b0, 1'b0, 2'd0}) begin
            failures++;
            $display("FAIL reset_a: got %b required %b", {a_state, a_out, a_buzz, a_busy, a_fcnt}, {S_IDLE, 1'b1, 1'b0, 1'b0, 2'd0});
        end
        checks++;
        if ({b_state, b_out, b_buzz, b_busy, b_fcnt} !== {S_IDLE, 1'b1, 1'b0, 1'b0, 2'd0}) begin
            failures++;
            $display("FAIL reset_b: got %b required %b", {b_state, b_out, b_buzz, b_busy, b_fcnt}, {S_IDLE, 1'b1, 1'b0, 1'b0, 2'd0});
        end
    endtask

    task automatic test_open_relock();
        drive_code(1'b0, DEF_CODE);
        checks++;
        if ({a_state, a_busy, a_out} !== {S_CHECK, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL open_edge16: got %b required %b", {a_state, a_busy, a_out}, {S_CHECK, 1'b1, 1'b1});
        end
        tick();
        m_fail_a = 0;
        checks++;
        if ({a_state, a_out, a_busy, a_fcnt} !== {S_OPEN, 1'b0, 1'b0, 2'd0}) begin
            failures++;
            $display("FAIL open_edge17: got %b required %b", {a_state, a_out, a_busy, a_fcnt}, {S_OPEN, 1'b0, 1'b0, 2'd0});
        end
        repeat (30) tick();
        checks++;
        if (a_state !== S_OPEN) begin
            failures++;
            $display("FAIL stay_open: got %0d required %0d", a_state, S_OPEN);
        end
        a_relock = 1'b1;
        tick();
        a_relock = 1'b0;
        checks++;
        if ({a_state, a_out} !== {S_IDLE, 1'b1}) begin
            failures++;
            $display("FAIL relock: got %b required %b", {a_state, a_out}, {S_IDLE, 1'b1});
        end
    endtask

    task automatic test_fail_timing();
        logic [15:0] bad [2];
        bad[0] = 16'd5939;
        bad[1] = 16'h9732;
        for (int i = 0; i < 2; i++) begin
            drive_code(1'b0, bad[i]);
            checks++;
            if (a_state !== S_CHECK) begin
                failures++;
                $display("FAIL fail_edge16[%0d]: got %0d required %0d", i, a_state, S_CHECK);
            end
            tick();
            checks++;
            if ({a_state, a_out} !== {S_FAIL, 1'b1}) begin
                failures++;
                $display("FAIL fail_edge17[%0d]: got %b required %b", i, {a_state, a_out}, {S_FAIL, 1'b1});
            end
            tick();
            m_fail_a++;
            checks++;
            if ({a_state, a_fcnt} !== {S_IDLE, 2'(m_fail_a)}) begin
                failures++;
                $display("FAIL fail_cnt[%0d]: got %b required %b", i, {a_state, a_fcnt}, {S_IDLE, 2'(m_fail_a)});
            end
        end
        drive_code(1'b0, m_code_a);
        tick();
        m_fail_a = 0;
        checks++;
        if ({a_state, a_out, a_fcnt} !== {S_OPEN, 1'b0, 2'd0}) begin
            failures++;
            $display("FAIL open_after_two_fails: got %b required %b", {a_state, a_out, a_fcnt}, {S_OPEN, 1'b0, 2'd0});
        end
        a_relock = 1'b1;
        tick();
        a_relock = 1'b0;
    endtask

    task automatic test_lockout();
        logic [15:0] c;
        int n;
        while (m_fail_a < MT) begin
            c = 16'($urandom);
            if (c == m_code_a) c = ~c;
            drive_code(1'b0, c);
            tick();
            checks++;
            if (a_state !== S_FAIL) begin
                failures++;
                $display("FAIL lock_fail_state: got %0d required %0d", a_state, S_FAIL);
            end
            tick();
            m_fail_a++;
        end
        checks++;
        if ({a_state, a_buzz, a_out, a_busy} !== {S_LOCKOUT, 1'b1, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL lockout_entry: got %b required %b", {a_state, a_buzz, a_out, a_busy}, {S_LOCKOUT, 1'b1, 1'b1, 1'b1});
        end
        n = 0;
        while (a_buzz === 1'b1 && n < 2 * LC) begin
            if (n == 5) begin
                a_code_in = m_code_a; a_code_valid = 1'b1;
                a_relock = 1'b1; a_prog_en = 1'b1; a_prog_code = ~m_code_a;
            end else begin
                a_code_valid = 1'b0; a_relock = 1'b0; a_prog_en = 1'b0;
            end
            n++;
            tick();
        end
        a_code_valid = 1'b0; a_relock = 1'b0; a_prog_en = 1'b0;
        checks++;
        if (n !== LC) begin
            failures++;
            $display("FAIL buzz_cycles: got %0d required %0d", n, LC);
        end
        m_fail_a = 0;
        checks++;
        if ({a_state, a_fcnt, a_out} !== {S_IDLE, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL lockout_exit: got %b required %b", {a_state, a_fcnt, a_out}, {S_IDLE, 2'd0, 1'b1});
        end
        drive_code(1'b0, m_code_a);
        tick();
        checks++;
        if (a_state !== S_OPEN) begin
            failures++;
            $display("FAIL code_kept_after_lockout: got %0d required %0d", a_state, S_OPEN);
        end
        a_relock = 1'b1;
        tick();
        a_relock = 1'b0;
    endtask

    task automatic test_prog();
        logic [15:0] q;
        drive_code(1'b0, m_code_a);
        tick();
        a_prog_en = 1'b1; a_prog_code = 16'h00FF;
        tick();
        a_prog_en = 1'b0;
        m_code_a = 16'h00FF;
        a_relock = 1'b1;
        tick();
        a_relock = 1'b0;
        drive_code(1'b0, DEF_CODE);
        tick();
        checks++;
        if (a_state !== S_FAIL) begin
            failures++;
            $display("FAIL old_code_rejected: got %0d required %0d", a_state, S_FAIL);
        end
        tick();
        m_fail_a++;
        drive_code(1'b0, 16'h00FF);
        tick();
        m_fail_a = 0;
        checks++;
        if ({a_state, a_fcnt} !== {S_OPEN, 2'd0}) begin
            failures++;
            $display("FAIL new_code_accepted: got %b required %b", {a_state, a_fcnt}, {S_OPEN, 2'd0});
        end
        do q = 16'($urandom); while (q == DEF_CODE || q == 16'h00FF);
        a_prog_en = 1'b1; a_prog_code = q; a_relock = 1'b1;
        tick();
        a_prog_en = 1'b0; a_relock = 1'b0;
        m_code_a = q;
        drive_code(1'b0, q);
        tick();
        checks++;
        if (a_state !== S_OPEN) begin
            failures++;
            $display("FAIL prog_with_relock: got %0d required %0d", a_state, S_OPEN);
        end
        a_relock = 1'b1;
        tick();
        a_relock = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] c;
        bit good;
        for (int i = 0; i < 16; i++) begin
            good = ($urandom_range(0, 1) == 1);
            if (good) begin
                c = m_code_a;
            end else begin
                c = 16'($urandom);
                if (c == m_code_a) c = ~c;
            end
            drive_code(1'b0, c);
            tick();
            if (good) begin
                m_fail_a = 0;
                checks++;
                if ({a_state, a_out, a_fcnt} !== {S_OPEN, 1'b0, 2'd0}) begin
                    failures++;
                    $display("FAIL rnd_open[%0d]: got %b required %b", i, {a_state, a_out, a_fcnt}, {S_OPEN, 1'b0, 2'd0});
                end
                if ($urandom_range(0, 1) == 1) begin
                    a_prog_en = 1'b1; a_prog_code = 16'($urandom);
                    m_code_a = a_prog_code;
                end
                a_relock = 1'b1;
                tick();
                a_relock = 1'b0; a_prog_en = 1'b0;
            end else begin
                checks++;
                if (a_state !== S_FAIL) begin
                    failures++;
                    $display("FAIL rnd_fail[%0d]: got %0d required %0d", i, a_state, S_FAIL);
                end
                tick();
                m_fail_a++;
                checks++;
                if (a_fcnt !== 2'(m_fail_a)) begin
                    failures++;
                    $display("FAIL rnd_fcnt[%0d]: got %0d required %0d", i, a_fcnt, m_fail_a);
                end
                if (m_fail_a == MT) begin
                    repeat (LC) tick();
                    m_fail_a = 0;
                end
            end
            checks++;
            if ({a_state, a_out, a_buzz, a_fcnt} !== {S_IDLE, 1'b1, 1'b0, 2'(m_fail_a)}) begin
                failures++;
                $display("FAIL rnd_idle[%0d]: got %b required %b", i, {a_state, a_out, a_buzz, a_fcnt}, {S_IDLE, 1'b1, 1'b0, 2'(m_fail_a)});
            end
        end
    endtask

    task automatic test_auto_relock();
        logic [15:0] r;
        drive_code(1'b1, m_code_b);
        tick();
        checks++;
        if ({b_state, b_out} !== {S_OPEN, 1'b0}) begin
            failures++;
            $display("FAIL b_open: got %b required %b", {b_state, b_out}, {S_OPEN, 1'b0});
        end
        repeat (OCB - 1) tick();
        checks++;
        if ({b_state, b_out} !== {S_OPEN, 1'b0}) begin
            failures++;
            $display("FAIL b_open_cycle19: got %b required %b", {b_state, b_out}, {S_OPEN, 1'b0});
        end
        tick();
        checks++;
        if ({b_state, b_out} !== {S_IDLE, 1'b1}) begin
            failures++;
            $display("FAIL b_auto_relock: got %b required %b", {b_state, b_out}, {S_IDLE, 1'b1});
        end
        b_prog_en = 1'b1; b_prog_code = 16'h00FF;
        tick();
        b_prog_en = 1'b0;
        drive_code(1'b1, m_code_b);
        tick();
        checks++;
        if (b_state !== S_OPEN) begin
            failures++;
            $display("FAIL b_prog_locked_ignored: got %0d required %0d", b_state, S_OPEN);
        end
        repeat (OCB - 1) tick();
        do r = 16'($urandom); while (r == m_code_b);
        b_prog_en = 1'b1; b_prog_code = r;
        tick();
        b_prog_en = 1'b0;
        m_code_b = r;
        checks++;
        if (b_state !== S_IDLE) begin
            failures++;
            $display("FAIL b_timeout_with_prog: got %0d required %0d", b_state, S_IDLE);
        end
        drive_code(1'b1, r);
        tick();
        checks++;
        if (b_state !== S_OPEN) begin
            failures++;
            $display("FAIL b_prog_at_timeout: got %0d required %0d", b_state, S_OPEN);
        end
        b_relock = 1'b1;
        tick();
        b_relock = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] c;
        a_code_in = m_code_a; a_code_valid = 1'b1;
        tick();
        a_code_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        m_code_a = DEF_CODE; m_code_b = DEF_CODE; m_fail_a = 0;
        checks++;
        if ({a_state, a_out, a_buzz, a_busy, a_fcnt} !== {S_IDLE, 1'b1, 1'b0, 1'b0, 2'd0}) begin
            failures++;
            $display("FAIL reset_mid_check: got %b required %b", {a_state, a_out, a_buzz, a_busy, a_fcnt}, {S_IDLE, 1'b1, 1'b0, 1'b0, 2'd0});
        end
        drive_code(1'b0, DEF_CODE);
        tick();
        checks++;
        if (a_state !== S_OPEN) begin
            failures++;
            $display("FAIL reset_restores_code: got %0d required %0d", a_state, S_OPEN);
        end
        a_relock = 1'b1;
        tick();
        a_relock = 1'b0;
        while (m_fail_a < MT) begin
            c = 16'($urandom);
            if (c == m_code_a) c = ~c;
            drive_code(1'b0, c);
            repeat (2) tick();
            m_fail_a++;
        end
        repeat (10) tick();
        checks++;
        if ({a_state, a_buzz} !== {S_LOCKOUT, 1'b1}) begin
            failures++;
            $display("FAIL pre_reset_lockout: got %b required %b", {a_state, a_buzz}, {S_LOCKOUT, 1'b1});
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        m_fail_a = 0;
        checks++;
        if ({a_state, a_out, a_buzz, a_busy, a_fcnt} !== {S_IDLE, 1'b1, 1'b0, 1'b0, 2'd0}) begin
            failures++;
            $display("FAIL reset_mid_lockout: got %b required %b", {a_state, a_out, a_buzz, a_busy, a_fcnt}, {S_IDLE, 1'b1, 1'b0, 1'b0, 2'd0});
        end
    endtask

    initial begin
        test_reset();
        test_open_relock();
        test_fail_timing();
        test_lockout();
        test_prog();
        test_random();
        test_auto_relock();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
